trng_pool_ctrl: RTL and testbench
=================================

# trng_pool_ctrl

Entropy-pool sequencer between the ADT7420 I2C temperature path and the 32-bit read-out port. It harvests one bit (temperature LSB) per new sensor conversion into a 512-bit pool, declares the pool ready when full, then serves it as 16 32-bit words on request before refilling. It is the single owner of pool fill/drain sequencing and, optionally, of the repetition-count health test.

## Interface
- POOL_BITS, 512, pool size in bits; multiple of WORD_W
- WORD_W, 32, read-out word width
- REP_LIMIT, 16, identical consecutive bits that trip the health test (2..255)

- CLK100MHZ  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-low
- En  in  1  harvest enable
- SAMPLE_STB  in  1  one-cycle pulse: new temperature conversion, already in CLK100MHZ domain
- SAMPLE_BIT  in  1  temperature LSB, valid with SAMPLE_STB
- RD_REQ  in  1  request next pool word
- READ_RESULT  out  WORD_W  word being served
- READ_VALID  out  1  one-cycle pulse, READ_RESULT valid
- POOL_READY  out  1  pool full, words available
- HEALTH_FAIL  out  1  sticky health-test failure

## Operation
- States: IDLE, FILL, READY.
- IDLE: En=0; SAMPLE_STB and RD_REQ ignored. En=1 -> FILL.
- FILL: each SAMPLE_STB stores SAMPLE_BIT at pool[bit_cnt], bit_cnt++. Strobe with bit_cnt==POOL_BITS-1 -> READY, bit_cnt=0. En=0 -> IDLE, bit_cnt=0 (partial pool discarded).
- READY: POOL_READY=1. Each cycle with RD_REQ=1 accepts one request: READ_RESULT=pool[WORD_W*w +: WORD_W], w++. Request with w==POOL_BITS/WORD_W-1 -> FILL (or IDLE if En=0), w=0, pool cleared. SAMPLE_STB ignored. En=0 does not discard a ready pool; it is drained, then IDLE.
- Word 0 holds first-harvested bits; bit k of pool is k-th accepted sample.
- RD_REQ outside READY: ignored, no READ_VALID.
- Health (macro on): run counter of identical consecutive accepted bits, counts samples only in FILL. Run reaching REP_LIMIT -> HEALTH_FAIL=1 (sticky until reset), bit_cnt=0, run restarts at 1 with current bit; harvesting continues. Run state cleared on entry to IDLE.

## Timing
- Reset (RST=0 at edge): state IDLE, READ_RESULT=0, READ_VALID=0, POOL_READY=0, HEALTH_FAIL=0, bit_cnt=0, w=0, pool=0.
- RD_REQ at t (READY) -> READ_VALID=1 and READ_RESULT at t+1; back-to-back requests: 16 words in 16 consecutive cycles.
- Final SAMPLE_STB at t -> POOL_READY=1 at t+1.
- Final accepted RD_REQ at t -> POOL_READY=0 and READ_VALID=1 (word 15) at t+1.
- READ_RESULT holds last served word between pulses.
- Simultaneous SAMPLE_STB and health trip: the tripping bit is not stored.

## Configuration
- TRNG_HEALTH_EN defined: repetition-count test and HEALTH_FAIL as above.
- Undefined: no run counter; HEALTH_FAIL tied 0; pools never discarded for entropy quality.

## Structure
- Package trng_pkg: state enum (IDLE, FILL, READY), POOL_BITS, WORD_W, WORDS = POOL_BITS/WORD_W, count widths via $clog2.
- Sub-module trng_rep_health: run counter and trip pulse, instantiated only under TRNG_HEALTH_EN.

## Test plan
- Reset then En=1, 512 strobes with bits alternating 0,1 -> POOL_READY at cycle after 512th strobe; 16 back-to-back RD_REQ -> 16 words 0xAAAAAAAA, POOL_READY low after last.
- En dropped after 300 strobes, raised again, 512 strobes of pattern 0011 repeating -> only new bits served, every word 0xCCCCCCCC.
- RD_REQ while FILL and SAMPLE_STB while READY -> no READ_VALID, pool content unchanged.
- TRNG_HEALTH_EN, REP_LIMIT=16: 16 consecutive 1s -> HEALTH_FAIL=1 at next cycle, bit_cnt=0; remains 1 through later valid pools until RST=0.
- Reset asserted mid-drain after word 5 -> all outputs reset values next cycle, state IDLE, READ_VALID never pulses again.
- En=0 while READY -> remaining 16 words still served, then IDLE with POOL_READY=0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and default sizing for the entropy-pool sequencer.
package trng_pkg;

    localparam int POOL_BITS = 512;
    localparam int WORD_W    = 32;
    localparam int WORDS     = POOL_BITS / WORD_W;
    localparam int REP_LIMIT = 16;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BIT_CNT_W  = cnt_w(POOL_BITS);
    localparam int WORD_CNT_W = cnt_w(WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_e;

endpackage

// File: rtl/trng_rep_health.sv
// Repetition-count health test: counts identical consecutive accepted bits and
// raises a combinational trip pulse on the sample that completes a run of REP_LIMIT.
module trng_rep_health #(
    parameter int REP_LIMIT = trng_pkg::REP_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic sample_i,
    input  logic bit_i,
    output logic trip_o
);
    import trng_pkg::*;

    localparam int RUN_W = cnt_w(REP_LIMIT + 1);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             last_q;

    // NOTE: trip is combinational so the parent can refuse to store the tripping bit in the same cycle.
    always_comb begin
        run_d  = RUN_W'(1);
        if (run_q != '0 && bit_i == last_q) begin
            run_d = run_q + RUN_W'(1);
        end
        trip_o = sample_i && (run_d == RUN_W'(REP_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else if (clr_i) begin
            run_q  <= '0;
        end else if (sample_i) begin
            run_q  <= trip_o ? RUN_W'(1) : run_d;
            last_q <= bit_i;
        end
    end

endmodule

// File: rtl/trng_pool_ctrl.sv
// Entropy-pool sequencer: harvests one bit per sensor strobe into a pool, then serves
// it as WORD_W-bit words. Define TRNG_HEALTH_EN to add the repetition-count health test.
module trng_pool_ctrl #(
    parameter int POOL_BITS = trng_pkg::POOL_BITS,
    parameter int WORD_W    = trng_pkg::WORD_W,
    parameter int REP_LIMIT = trng_pkg::REP_LIMIT
) (
    input  logic              CLK100MHZ,
    input  logic              RST,
    input  logic              En,
    input  logic              SAMPLE_STB,
    input  logic              SAMPLE_BIT,
    input  logic              RD_REQ,
    output logic [WORD_W-1:0] READ_RESULT,
    output logic              READ_VALID,
    output logic              POOL_READY,
    output logic              HEALTH_FAIL
);
    import trng_pkg::*;

    localparam int NUM_WORDS = POOL_BITS / WORD_W;
    localparam int PB_CNT_W  = cnt_w(POOL_BITS);
    localparam int PW_CNT_W  = cnt_w(NUM_WORDS);

    state_e               state_q;
    logic [POOL_BITS-1:0] pool_q;
    logic [PB_CNT_W-1:0]  bit_cnt_q;
    logic [PW_CNT_W-1:0]  word_cnt_q;
    logic [WORD_W-1:0]    read_result_q;
    logic                 read_valid_q;
    logic                 pool_ready_q;

    logic sample_acc;
    logic health_trip;

    assign sample_acc = (state_q == FILL) && En && SAMPLE_STB;

`ifdef TRNG_HEALTH_EN
    logic health_fail_q;

    trng_rep_health #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_health (
        .clk      (CLK100MHZ),
        .rst_n    (RST),
        .clr_i    (state_q == IDLE),
        .sample_i (sample_acc),
        .bit_i    (SAMPLE_BIT),
        .trip_o   (health_trip)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (!RST) begin
            health_fail_q <= 1'b0;
        end else if (health_trip) begin
            health_fail_q <= 1'b1;
        end
    end

    assign HEALTH_FAIL = health_fail_q;
`else
    assign health_trip = 1'b0;
    assign HEALTH_FAIL = 1'b0;
`endif

    // NOTE: the pool is a flop vector, not a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge CLK100MHZ) begin
        if (!RST) begin
            state_q       <= IDLE;
            pool_q        <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            read_result_q <= '0;
            read_valid_q  <= 1'b0;
            pool_ready_q  <= 1'b0;
        end else begin
            read_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bit_cnt_q  <= '0;
                    word_cnt_q <= '0;
                    if (En) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (!En) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                        pool_q    <= '0;
                    end else if (health_trip) begin
                        bit_cnt_q <= '0;
                    end else if (sample_acc) begin
                        pool_q[bit_cnt_q] <= SAMPLE_BIT;
                        if (bit_cnt_q == PB_CNT_W'(POOL_BITS - 1)) begin
                            state_q      <= READY;
                            pool_ready_q <= 1'b1;
                            bit_cnt_q    <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + PB_CNT_W'(1);
                        end
                    end
                end
                READY: begin
                    if (RD_REQ) begin
                        read_result_q <= pool_q[int'(word_cnt_q) * WORD_W +: WORD_W];
                        read_valid_q  <= 1'b1;
                        if (word_cnt_q == PW_CNT_W'(NUM_WORDS - 1)) begin
                            // Drain complete: a dropped En only takes effect here.
                            word_cnt_q   <= '0;
                            pool_q       <= '0;
                            pool_ready_q <= 1'b0;
                            state_q      <= En ? FILL : IDLE;
                        end else begin
                            word_cnt_q <= word_cnt_q + PW_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign READ_RESULT = read_result_q;
    assign READ_VALID  = read_valid_q;
    assign POOL_READY  = pool_ready_q;

endmodule

// File: tb/tb_trng_pool_ctrl.sv
// Self-checking bench for trng_pool_ctrl: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model of the pool.
module tb_trng_pool_ctrl;

    localparam int POOL_BITS = 512;
    localparam int WORD_W    = 32;
    localparam int WORDS     = POOL_BITS / WORD_W;
    localparam int REP_LIMIT = 16;
`ifdef TRNG_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              stb = 1'b0;
    logic              sbit = 1'b0;
    logic              req = 1'b0;
    logic [WORD_W-1:0] READ_RESULT;
    logic              READ_VALID;
    logic              POOL_READY;
    logic              HEALTH_FAIL;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    trng_pool_ctrl #(
        .POOL_BITS (POOL_BITS),
        .WORD_W    (WORD_W),
        .REP_LIMIT (REP_LIMIT)
    ) dut (
        .CLK100MHZ   (clk),
        .RST         (rst_n),
        .En          (en),
        .SAMPLE_STB  (stb),
        .SAMPLE_BIT  (sbit),
        .RD_REQ      (req),
        .READ_RESULT (READ_RESULT),
        .READ_VALID  (READ_VALID),
        .POOL_READY  (POOL_READY),
        .HEALTH_FAIL (HEALTH_FAIL)
    );

    // Reference model: harvested bits kept in arrival order, words cut from that queue.
    bit          hq[$];
    bit          m_ready;
    bit          m_fill;
    int          m_served;
    int          m_run;
    bit          m_last;
    logic [31:0] e_result;
    bit          e_valid;
    bit          e_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            hq.delete();
            m_ready  = 1'b0;
            m_fill   = 1'b0;
            m_served = 0;
            m_run    = 0;
            m_last   = 1'b0;
            e_valid  = 1'b0;
            e_result = '0;
            e_fail   = 1'b0;
            return;
        end
        e_valid = 1'b0;
        if (m_ready) begin
            if (req) begin
                for (int j = 0; j < WORD_W; j++) e_result[j] = hq[WORD_W * m_served + j];
                e_valid = 1'b1;
                m_served++;
                if (m_served == WORDS) begin
                    m_ready  = 1'b0;
                    m_served = 0;
                    hq.delete();
                    m_fill   = en;
                end
            end
        end else if (m_fill) begin
            if (!en) begin
                m_fill = 1'b0;
                hq.delete();
            end else if (stb) begin
                if (m_run > 0 && sbit == m_last) m_run++;
                else m_run = 1;
                m_last = sbit;
                if (HEALTH && m_run == REP_LIMIT) begin
                    e_fail = 1'b1;
                    m_run  = 1;
                    hq.delete();
                end else begin
                    hq.push_back(sbit);
                    if (hq.size() == POOL_BITS) m_ready = 1'b1;
                end
            end
        end else begin
            m_run = 0;
            if (en) m_fill = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("valid",  READ_VALID,  e_valid);
        check("ready",  POOL_READY,  m_ready);
        check("hfail",  HEALTH_FAIL, e_fail);
        check("result", READ_RESULT, e_result);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        stb   = 1'b0;
        req   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic feed(input bit b, input bit with_req);
        stb  = 1'b1;
        sbit = b;
        req  = with_req;
        tick();
        stb  = 1'b0;
        req  = 1'b0;
    endtask

    task automatic drain_const(input int n, input logic [31:0] exp_word);
        for (int i = 0; i < n; i++) begin
            req = 1'b1;
            tick();
            check("drain_valid", READ_VALID, 1'b1);
            check("drain_word", READ_RESULT, exp_word);
        end
        req = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_result", READ_RESULT, 32'h0);
        check("rst_valid",  READ_VALID,  1'b0);
        check("rst_ready",  POOL_READY,  1'b0);
        check("rst_hfail",  HEALTH_FAIL, 1'b0);

        // Alternating 0,1 with stray requests while filling
        en = 1'b1;
        tick();
        for (int i = 0; i < POOL_BITS; i++) begin
            feed(i[0], (i % 37) == 5);
            if (i == POOL_BITS - 2) check("alt_not_ready", POOL_READY, 1'b0);
            if (i < POOL_BITS - 1)  check("fill_no_valid", READ_VALID, 1'b0);
        end
        check("alt_ready", POOL_READY, 1'b1);
        for (int i = 0; i < 4; i++) feed(1'b1, 1'b0);
        check("ready_stb_ignored", POOL_READY, 1'b1);
        drain_const(WORDS, 32'hAAAAAAAA);
        check("alt_drained", POOL_READY, 1'b0);

        // Partial pool discarded when En drops; only the 0011 pool is served
        for (int i = 0; i < 300; i++) feed($urandom_range(0, 1), 1'b0);
        en = 1'b0;
        tick();
        tick();
        en = 1'b1;
        tick();
        for (int i = 0; i < POOL_BITS; i++) feed((i % 4) >= 2, 1'b0);
        check("cc_ready", POOL_READY, 1'b1);
        drain_const(WORDS, 32'hCCCCCCCC);

        // En dropped while READY: pool still drained, then IDLE
        for (int i = 0; i < POOL_BITS; i++) feed($urandom_range(0, 1), 1'b0);
        en = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            req = 1'b1;
            tick();
            check("en0_valid", READ_VALID, 1'b1);
            req = 1'b0;
            tick();
        end
        check("en0_idle_ready", POOL_READY, 1'b0);
        for (int i = 0; i < 10; i++) feed(1'b1, 1'b1);
        check("en0_still_idle", POOL_READY, 1'b0);

        // Reset mid-drain after word 5
        en = 1'b1;
        tick();
        for (int i = 0; i < POOL_BITS; i++) feed($urandom_range(0, 1), 1'b0);
        for (int i = 0; i < 6; i++) begin
            req = 1'b1;
            tick();
        end
        req   = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mid_rst_result", READ_RESULT, 32'h0);
        check("mid_rst_valid",  READ_VALID,  1'b0);
        check("mid_rst_ready",  POOL_READY,  1'b0);
        rst_n = 1'b1;
        en    = 1'b0;
        req   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_no_valid", READ_VALID, 1'b0);
        end
        req = 1'b0;

        // Repetition run of 16 ones
        do_reset();
        en = 1'b1;
        tick();
        feed(1'b0, 1'b0);
        for (int i = 0; i < REP_LIMIT; i++) feed(1'b1, 1'b0);
`ifdef TRNG_HEALTH_EN
        check("trip_hfail", HEALTH_FAIL, 1'b1);
        for (int i = 0; i < POOL_BITS; i++) begin
            feed(i[0], 1'b0);
            if (i == POOL_BITS - 2) check("trip_restart_not_ready", POOL_READY, 1'b0);
        end
        check("trip_restart_ready", POOL_READY, 1'b1);
        drain_const(WORDS, 32'hAAAAAAAA);
        check("trip_sticky", HEALTH_FAIL, 1'b1);
`else
        check("no_health_hfail", HEALTH_FAIL, 1'b0);
        for (int i = 0; i < POOL_BITS; i++) feed(i[0], 1'b0);
        for (int i = 0; i < WORDS; i++) begin
            req = 1'b1;
            tick();
        end
        req = 1'b0;
`endif
        do_reset();
        check("hfail_cleared", HEALTH_FAIL, 1'b0);

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            en   = ($urandom_range(0, 999) != 0);
            stb  = ($urandom_range(0, 1) == 1);
            sbit = $urandom_range(0, 1);
            req  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
